i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target (slave) for a single 7-bit address: receives write bytes, serves read
// bytes from tx_data_i, and only ever moves SDA while the synchronised SCL is low.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   input  logic [7:0] tx_data_i,
   output logic       tx_req_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
   } state_t;

   // Bit 1 = SCL, bit 0 = SDA; two sync flops plus one history flop per line.
   logic [1:0] pin;
   logic [1:0] sync1_reg, sync2_reg, hist_reg;

   assign pin = {scl_i, sda_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (!rst) begin
               sync1_reg[gi] <= 1'b1;
               sync2_reg[gi] <= 1'b1;
               hist_reg[gi]  <= 1'b1;
            end else begin
               sync1_reg[gi] <= pin[gi];
               sync2_reg[gi] <= sync1_reg[gi];
               hist_reg[gi]  <= sync2_reg[gi];
            end
         end
      end
   endgenerate

   logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

   assign scl       = sync2_reg[1];
   assign sda       = sync2_reg[0];
   assign scl_rise  = scl & ~hist_reg[1];
   assign scl_fall  = ~scl & hist_reg[1];
   assign start_det = scl & hist_reg[0] & ~sda;
   assign stop_det  = scl & ~hist_reg[0] & sda;

   state_t     state_reg, state_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic       rw_reg, rw_next;
   logic       ack_reg, ack_next;
   logic       oe_reg, oe_next;
   logic       tx_req_reg, tx_req_next;
   logic       rx_valid_reg, rx_valid_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'h00;
         rx_data_reg  <= 8'h00;
         rw_reg       <= 1'b0;
         ack_reg      <= 1'b0;
         oe_reg       <= 1'b0;
         tx_req_reg   <= 1'b0;
         rx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         rx_data_reg  <= rx_data_next;
         rw_reg       <= rw_next;
         ack_reg      <= ack_next;
         oe_reg       <= oe_next;
         tx_req_reg   <= tx_req_next;
         rx_valid_reg <= rx_valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      rx_data_next  = rx_data_reg;
      rw_next       = rw_reg;
      ack_next      = ack_reg;
      oe_next       = oe_reg;
      tx_req_next   = 1'b0;
      rx_valid_next = 1'b0;

      // Bus conditions override everything, STOP before START.
      if (stop_det) begin
         state_next = IDLE;
         oe_next    = 1'b0;
      end else if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = 4'd0;
         shift_next   = 8'h00;
         oe_next      = 1'b0;
      end else begin
         case (state_reg)
            ADDR: begin
               if (scl_rise) begin
                  shift_next   = {shift_reg[6:0], sda};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  if (shift_reg[7:1] == TARGET_ADDR) begin
                     state_next = ADDR_ACK;
                     oe_next    = 1'b1;
                     rw_next    = shift_reg[0];
                  end else begin
                     state_next = WAIT_STOP;
                     oe_next    = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_reg) begin
                     state_next  = TX;
                     shift_next  = tx_data_i;
                     tx_req_next = 1'b1;
                     oe_next     = ~tx_data_i[7];
                  end else begin
                     state_next = RX;
                     oe_next    = 1'b0;
                  end
               end
            end
            RX: begin
               if (scl_rise) begin
                  shift_next   = {shift_reg[6:0], sda};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     rx_data_next  = {shift_reg[6:0], sda};
                     rx_valid_next = 1'b1;
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  state_next   = RX_ACK;
                  bit_cnt_next = 4'd0;
                  oe_next      = 1'b1;
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  state_next = RX;
                  oe_next    = 1'b0;
               end
            end
            TX: begin
               // The MSB goes out at load time; each later fall presents the next bit.
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     state_next   = TX_ACK;
                     bit_cnt_next = 4'd0;
                     oe_next      = 1'b0;
                  end else begin
                     shift_next = {shift_reg[6:0], 1'b0};
                     oe_next    = ~shift_reg[6];
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  ack_next = sda;
               end else if (scl_fall) begin
                  if (!ack_reg) begin
                     state_next   = TX;
                     bit_cnt_next = 4'd0;
                     shift_next   = tx_data_i;
                     tx_req_next  = 1'b1;
                     oe_next      = ~tx_data_i[7];
                  end else begin
                     state_next = WAIT_STOP;
                     oe_next    = 1'b0;
                  end
               end
            end
            default: begin
               oe_next = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe_o   = oe_reg;
   assign tx_req_o   = tx_req_reg;
   assign rx_data_o  = rx_data_reg;
   assign rx_valid_o = rx_valid_reg;
   assign busy_o     = (state_reg != IDLE);

endmodule
